// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_responder_pkg;

  localparam int unsigned BE_LEN = 4;

  typedef enum logic [1:0] {
    MEMR_IDLE = 2'd0,
    MEMR_WAIT = 2'd1,
    MEMR_RESP = 2'd2
  } memr_state_e;

endpackage

// File: rtl/mem_responder_array.sv
// Word array with synchronous per-lane writes and a combinational read port.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_LEN   = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BE_LEN-1:0]     be,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [DATA_LEN-1:0]   wdata,
  output logic [DATA_LEN-1:0]   rdata
);

  localparam int unsigned LANE_W = DATA_LEN / BE_LEN;

  logic [DATA_LEN-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < BE_LEN; i++) begin
        if (be[i]) mem[index][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, programmable wait
// states, then a held response carrying load data or an error flag.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_LEN    = 32,
  parameter int unsigned DATA_LEN    = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  input  logic [BE_LEN-1:0]   req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_rdata,
  output logic                resp_err
);

  localparam bit            ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]    WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_LEN-1:0] IN_RANGE_MASK =
    (ADDR_LEN'(1) << (DEPTH_LOG2 + 2)) - ADDR_LEN'(1);

  memr_state_e state, state_nx;
  logic [3:0]  cnt, cnt_nx;

  logic                lat_we;
  logic [ADDR_LEN-1:0] lat_addr;
  logic [DATA_LEN-1:0] lat_wdata;
  logic [BE_LEN-1:0]   lat_be;

  logic                  accept, commit;
  logic                  acc_we, acc_err;
  logic [ADDR_LEN-1:0]   acc_addr;
  logic [DATA_LEN-1:0]   acc_wdata, arr_rdata;
  logic [BE_LEN-1:0]     acc_be;
  logic [DEPTH_LOG2-1:0] acc_idx;

  assign accept = (state == MEMR_IDLE) && req_valid;
  assign commit = ((state == MEMR_WAIT) && (cnt == '0)) || (ZERO_WAIT && accept);

  // With no wait states the access happens on the accept edge itself, so the
  // array port is fed from the live request while idle and the latch otherwise.
  always_comb begin
    if (state == MEMR_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
    end
  end

  assign acc_err = (|acc_addr[1:0]) || (|(acc_addr & ~IN_RANGE_MASK));
  assign acc_idx = acc_addr[DEPTH_LOG2+1:2];

  mem_array #(
    .DATA_LEN   (DATA_LEN),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (commit && acc_we && !acc_err),
    .be    (acc_be),
    .index (acc_idx),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      MEMR_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (ZERO_WAIT) begin
            state_nx = MEMR_RESP;
          end else begin
            state_nx = MEMR_WAIT;
            cnt_nx   = WAIT_LOAD;
          end
        end
      end
      MEMR_WAIT: begin
        if (cnt == '0) state_nx = MEMR_RESP;
        else           cnt_nx   = cnt - 4'd1;
      end
      MEMR_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = MEMR_IDLE;
      end
      default: state_nx = MEMR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= MEMR_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
      if (commit) begin
        resp_err   <= acc_err;
        resp_rdata <= (!acc_we && !acc_err) ? arr_rdata : '0;
      end
    end
  end

endmodule
